frame_tx: RTL and testbench

//  Serial transmit stage directly downstream of the Hamming/SEC-DED encoder.

---
 rtl/frame_tx_if.sv | 20 ++
 rtl/frame_tx.sv | 119 +++++++++++
 tb/tb_frame_tx.sv | 260 ++++++++++++++++++++++++++
 3 files changed

// File: rtl/frame_tx_if.sv
// Codeword handshake between the SEC-DED encoder and the serial transmit stage.
interface frame_tx_if #(
  parameter int FRAME_SIZE = 16
);
  logic [FRAME_SIZE-1:0] frame_in;
  logic                  frame_valid;
  logic                  frame_ready;

  modport master (
    output frame_in,
    output frame_valid,
    input  frame_ready
  );

  modport slave (
    input  frame_in,
    input  frame_valid,
    output frame_ready
  );
endinterface

// File: rtl/frame_tx.sv
// Serial optical-line transmitter: start bit (1), codeword LSB first, stop bits (0).
// The line idles low; every line bit is held for CLKS_PER_BIT clock cycles.
module frame_tx #(
  parameter int FRAME_SIZE   = 16,
  parameter int CLKS_PER_BIT = 8,
  parameter int STOP_BITS    = 1
) (
  input  logic       clk,
  input  logic       reset,
  frame_tx_if.slave  bus,
  output logic       tx,
  output logic       busy,
  output logic       done
);

  localparam int CW = $clog2(CLKS_PER_BIT * STOP_BITS) + 1;
  localparam int BW = $clog2(FRAME_SIZE) + 1;

  localparam logic [CW-1:0] BIT_LAST   = CW'(CLKS_PER_BIT - 1);
  localparam logic [CW-1:0] STOP_LAST  = CW'(CLKS_PER_BIT * STOP_BITS - 1);
  localparam logic [BW-1:0] FRAME_LAST = BW'(FRAME_SIZE - 1);

  localparam logic [1:0] IDLE  = 2'd0;
  localparam logic [1:0] START = 2'd1;
  localparam logic [1:0] DATA  = 2'd2;
  localparam logic [1:0] STOP  = 2'd3;

  logic [1:0]            state_q, state_d;
  logic [CW-1:0]         cnt_q,   cnt_d;
  logic [BW-1:0]         bit_q,   bit_d;
  logic [FRAME_SIZE-1:0] shift_q, shift_d;
  logic                  tx_q,    tx_d;
  logic                  busy_q,  busy_d;
  logic                  done_q,  done_d;

  assign bus.frame_ready = (state_q == IDLE);
  assign tx              = tx_q;
  assign busy            = busy_q;
  assign done            = done_q;

  // Next-state: phase sequencing, per-bit cycle counting and shifting.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    bit_d   = bit_q;
    shift_d = shift_q;
    case (state_q)
      IDLE: begin
        if (bus.frame_valid) begin
          shift_d = bus.frame_in;
          cnt_d   = '0;
          bit_d   = '0;
          state_d = START;
        end
      end
      START: begin
        if (cnt_q == BIT_LAST) begin
          cnt_d   = '0;
          state_d = DATA;
        end else begin
          cnt_d = cnt_q + CW'(1);
        end
      end
      DATA: begin
        if (cnt_q == BIT_LAST) begin
          cnt_d   = '0;
          shift_d = shift_q >> 1;
          if (bit_q == FRAME_LAST) begin
            bit_d   = '0;
            state_d = STOP;
          end else begin
            bit_d = bit_q + BW'(1);
          end
        end else begin
          cnt_d = cnt_q + CW'(1);
        end
      end
      STOP: begin
        if (cnt_q == STOP_LAST) begin
          cnt_d   = '0;
          state_d = IDLE;
        end else begin
          cnt_d = cnt_q + CW'(1);
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // Outputs are decoded from the next state so the registered line and
  // status flags line up cycle-for-cycle with the state they describe.
  always_comb begin
    tx_d   = (state_d == START) | ((state_d == DATA) & shift_d[0]);
    busy_d = (state_d != IDLE);
    done_d = (state_d == STOP) && (cnt_d == STOP_LAST);
  end

  // State and output registers; reset aborts any frame in flight.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      bit_q   <= '0;
      shift_q <= '0;
      tx_q    <= 1'b0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      bit_q   <= bit_d;
      shift_q <= shift_d;
      tx_q    <= tx_d;
      busy_q  <= busy_d;
      done_q  <= done_d;
    end
  end

endmodule

// File: tb/tb_frame_tx.sv
// Scoreboard bench for frame_tx: the driver queues the expected line trace at
// each accept; per-instance monitors pop and compare every busy cycle.
module tb_frame_tx;

  typedef struct packed {
    logic tx;
    logic done;
  } exp_t;

  logic clk;
  logic reset;
  logic tx1, busy1, done1;
  logic tx2, busy2, done2;
  logic mon_en;

  int checks;
  int failures;

  exp_t q1[$];
  exp_t q2[$];

  frame_tx_if #(.FRAME_SIZE(16)) bus1 ();
  frame_tx_if #(.FRAME_SIZE(16)) bus2 ();

  frame_tx #(.FRAME_SIZE(16), .CLKS_PER_BIT(4), .STOP_BITS(1)) u1 (
    .clk   (clk),
    .reset (reset),
    .bus   (bus1.slave),
    .tx    (tx1),
    .busy  (busy1),
    .done  (done1)
  );

  frame_tx #(.FRAME_SIZE(16), .CLKS_PER_BIT(1), .STOP_BITS(2)) u2 (
    .clk   (clk),
    .reset (reset),
    .bus   (bus2.slave),
    .tx    (tx2),
    .busy  (busy2),
    .done  (done2)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached, act=running req=finished");
    $fatal(1, "watchdog expired");
  end

  task automatic chk(input string name, input logic act, input logic req);
    checks++;
    if (act !== req) begin
      failures++;
      $display("FAIL %s at %0t: act=%0b req=%0b", name, $time, act, req);
    end
  endtask

  task automatic fail_now(input string name);
    checks++;
    failures++;
    $display("FAIL %s at %0t: act=timeout req=event", name, $time);
  endtask

  // Monitor for the CLKS_PER_BIT=4 instance.
  always @(negedge clk) begin
    if (mon_en && !reset) begin
      if (busy1) begin
        if (q1.size() == 0) begin
          fail_now("u1_unexpected_busy");
        end else begin
          exp_t e;
          e = q1.pop_front();
          chk("u1_tx", tx1, e.tx);
          chk("u1_done", done1, e.done);
          chk("u1_ready_busy", bus1.frame_ready, 1'b0);
        end
      end else begin
        chk("u1_tx_idle", tx1, 1'b0);
        chk("u1_done_idle", done1, 1'b0);
        chk("u1_ready_idle", bus1.frame_ready, 1'b1);
      end
    end
  end

  // Monitor for the CLKS_PER_BIT=1, STOP_BITS=2 instance.
  always @(negedge clk) begin
    if (mon_en && !reset) begin
      if (busy2) begin
        if (q2.size() == 0) begin
          fail_now("u2_unexpected_busy");
        end else begin
          exp_t e;
          e = q2.pop_front();
          chk("u2_tx", tx2, e.tx);
          chk("u2_done", done2, e.done);
          chk("u2_ready_busy", bus2.frame_ready, 1'b0);
        end
      end else begin
        chk("u2_tx_idle", tx2, 1'b0);
        chk("u2_done_idle", done2, 1'b0);
        chk("u2_ready_idle", bus2.frame_ready, 1'b1);
      end
    end
  end

  // Line trace for CLKS_PER_BIT=4, STOP_BITS=1: 4 start, 16x4 data, 4 stop.
  task automatic push_u1(input logic [15:0] f);
    exp_t e;
    for (int unsigned i = 0; i < 4; i++) begin
      e.tx = 1'b1; e.done = 1'b0; q1.push_back(e);
    end
    for (int unsigned b = 0; b < 16; b++) begin
      for (int unsigned i = 0; i < 4; i++) begin
        e.tx = f[b]; e.done = 1'b0; q1.push_back(e);
      end
    end
    for (int unsigned i = 0; i < 4; i++) begin
      e.tx = 1'b0; e.done = (i == 3); q1.push_back(e);
    end
  endtask

  // Present a frame to u1, wait for acceptance, queue its trace.
  task automatic send1(input logic [15:0] f, output longint t_acc);
    int n;
    t_acc = 0;
    bus1.frame_in    = f;
    bus1.frame_valid = 1'b1;
    n = 0;
    while (!bus1.frame_ready && n < 200) begin
      @(posedge clk); #1;
      n++;
    end
    if (!bus1.frame_ready) begin
      fail_now("u1_accept_timeout");
      bus1.frame_valid = 1'b0;
    end else begin
      @(posedge clk);
      t_acc = longint'($time);
      push_u1(f);
      #1;
      bus1.frame_valid = 1'b0;
      chk("u1_first_cycle_busy", busy1, 1'b1);
      chk("u1_first_cycle_tx", tx1, 1'b1);
    end
  endtask

  task automatic wait_idle1;
    int n;
    n = 0;
    while ((busy1 || q1.size() != 0) && n < 300) begin
      @(posedge clk); #1;
      n++;
    end
    if (n == 300) fail_now("u1_idle_timeout");
    @(posedge clk); #1;
  endtask

  longint ta, tb_acc, tdummy;
  logic [18:0] exp2;

  initial begin
    checks   = 0;
    failures = 0;
    mon_en   = 1'b0;
    reset    = 1'b1;
    bus1.frame_in = '0; bus1.frame_valid = 1'b0;
    bus2.frame_in = '0; bus2.frame_valid = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    reset = 1'b0;

    // Reset state
    chk("rst_tx", tx1, 1'b0);
    chk("rst_busy", busy1, 1'b0);
    chk("rst_done", done1, 1'b0);
    chk("rst_ready", bus1.frame_ready, 1'b1);
    chk("rst_u2_busy", busy2, 1'b0);
    chk("rst_u2_ready", bus2.frame_ready, 1'b1);
    mon_en = 1'b1;
    @(posedge clk); #1;

    // Basic frame A5C3, then FFFF held valid through the whole first frame
    send1(16'hA5C3, ta);
    send1(16'hFFFF, tb_acc);
    checks++;
    if (tb_acc - ta != 64'd730) begin
      failures++;
      $display("FAIL accept_spacing: act=%0d cycles req=73 cycles", (tb_acc - ta) / 10);
    end
    wait_idle1();

    // Reset during DATA bit 5 (cycle 26 after accept), then a clean 0001
    send1(16'hA5C3, tdummy);
    repeat (25) @(posedge clk);
    #1;
    reset = 1'b1;
    q1.delete();
    @(posedge clk); #1;
    reset = 1'b0;
    chk("abort_tx", tx1, 1'b0);
    chk("abort_busy", busy1, 1'b0);
    chk("abort_done", done1, 1'b0);
    chk("abort_ready", bus1.frame_ready, 1'b1);
    send1(16'h0001, tdummy);
    wait_idle1();

    // Edge patterns
    send1(16'h0000, tdummy);
    wait_idle1();
    send1(16'hFFFF, tdummy);
    wait_idle1();

    // Reset and valid on the same edge: no accept
    reset = 1'b1;
    bus1.frame_in    = 16'hFFFF;
    bus1.frame_valid = 1'b1;
    @(posedge clk); #1;
    reset = 1'b0;
    bus1.frame_valid = 1'b0;
    chk("rstvalid_busy", busy1, 1'b0);
    chk("rstvalid_tx", tx1, 1'b0);
    repeat (3) @(posedge clk);
    #1;
    chk("rstvalid_busy_later", busy1, 1'b0);

    // CLKS_PER_BIT=1, STOP_BITS=2, frame 8001: 1,1,0x14,1,0,0
    exp2 = 19'h10003;
    bus2.frame_in    = 16'h8001;
    bus2.frame_valid = 1'b1;
    if (!bus2.frame_ready) fail_now("u2_not_ready");
    @(posedge clk);
    for (int unsigned i = 0; i < 19; i++) begin
      exp_t e;
      e.tx = exp2[i];
      e.done = (i == 18);
      q2.push_back(e);
    end
    #1;
    bus2.frame_valid = 1'b0;
    bus2.frame_in    = 16'h0000;
    chk("u2_first_cycle_tx", tx2, 1'b1);
    begin
      int n;
      n = 0;
      while ((busy2 || q2.size() != 0) && n < 100) begin
        @(posedge clk); #1;
        n++;
      end
      if (n == 100) fail_now("u2_idle_timeout");
    end
    repeat (2) @(posedge clk);
    #1;

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
